// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
// Optional macro ID_EX_FWD_EN: enables EX/MEM and MEM/WB forwarding; without it, RAW hazards stall.
module id_ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [WIDTH-1:0] i_id_pc,
   input  logic [4:0]       i_id_rs1_addr,
   input  logic [4:0]       i_id_rs2_addr,
   input  logic [4:0]       i_id_rd_addr,
   input  logic [WIDTH-1:0] i_id_rs1_data,
   input  logic [WIDTH-1:0] i_id_rs2_data,
   input  logic [WIDTH-1:0] i_id_imm,
   input  logic [3:0]       i_id_alu_ctrl,
   input  logic             i_id_src0_pc,
   input  logic             i_id_src1_imm,
   input  logic             i_id_reg_write,
   input  logic             i_id_mem_read,
   input  logic             i_id_mem_write,
   input  logic             i_flush,
   input  logic [4:0]       i_exm_rd_addr,
   input  logic             i_exm_reg_write,
   input  logic [WIDTH-1:0] i_exm_result,
   input  logic [4:0]       i_mwb_rd_addr,
   input  logic             i_mwb_reg_write,
   input  logic [WIDTH-1:0] i_mwb_result,
   output logic             o_stall,
   output logic             o_ex_valid,
   output logic [3:0]       o_alu_ctrl,
   output logic [WIDTH-1:0] o_op_0,
   output logic [WIDTH-1:0] o_op_1,
   output logic [WIDTH-1:0] o_store_data,
   output logic [WIDTH-1:0] o_pc,
   output logic [4:0]       o_rd_addr,
   output logic             o_reg_write,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic [31:0]      o_stall_cnt
);

   logic             ex_valid_q, ex_valid_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [4:0]       rd_q, rd_d;
   logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
   logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [3:0]       alu_ctrl_q, alu_ctrl_d;
   logic             src0_pc_q, src0_pc_d;
   logic             src1_imm_q, src1_imm_d;
   logic             reg_write_q, reg_write_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;
   logic             stall;
   logic [WIDTH-1:0] rs1_fwd;
   logic [WIDTH-1:0] rs2_fwd;

`ifdef ID_EX_FWD_EN
   logic [4:0]       rs1_addr_q, rs1_addr_d;
   logic [4:0]       rs2_addr_q, rs2_addr_d;
   logic             load_use;

   // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
   function automatic logic [WIDTH-1:0] fwd_sel(input logic [4:0] src, input logic [WIDTH-1:0] rf_data);
      if (i_exm_reg_write && (i_exm_rd_addr != 5'd0) && (i_exm_rd_addr == src))
         return i_exm_result;
      else if (i_mwb_reg_write && (i_mwb_rd_addr != 5'd0) && (i_mwb_rd_addr == src))
         return i_mwb_result;
      else
         return rf_data;
   endfunction

   assign rs1_fwd  = fwd_sel(rs1_addr_q, rs1_data_q);
   assign rs2_fwd  = fwd_sel(rs2_addr_q, rs2_data_q);
   assign load_use = ex_valid_q && mem_read_q && (rd_q != 5'd0) &&
                     ((!i_id_src0_pc && (i_id_rs1_addr == rd_q)) || (i_id_rs2_addr == rd_q));
   assign stall    = i_id_valid && load_use && !i_flush;
`else
   logic unused_fwd_data;

   // Without forwarding, any in-flight writer of a used source must drain first.
   function automatic logic raw_hazard(input logic [4:0] src);
      return (src != 5'd0) &&
             ((ex_valid_q && reg_write_q && (rd_q == src)) ||
              (i_exm_reg_write && (i_exm_rd_addr == src)) ||
              (i_mwb_reg_write && (i_mwb_rd_addr == src)));
   endfunction

   assign unused_fwd_data = ^{i_exm_result, i_mwb_result};
   assign rs1_fwd = rs1_data_q;
   assign rs2_fwd = rs2_data_q;
   assign stall   = i_id_valid && !i_flush &&
                    ((!i_id_src0_pc && raw_hazard(i_id_rs1_addr)) || raw_hazard(i_id_rs2_addr));
`endif

   always_comb begin
      ex_valid_d  = 1'b0;
      pc_d        = pc_q;
      rd_d        = rd_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      alu_ctrl_d  = alu_ctrl_q;
      src0_pc_d   = src0_pc_q;
      src1_imm_d  = src1_imm_q;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
`ifdef ID_EX_FWD_EN
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
`endif
      if (i_id_valid && !stall && !i_flush) begin
         ex_valid_d  = 1'b1;
         pc_d        = i_id_pc;
         rd_d        = i_id_rd_addr;
         rs1_data_d  = i_id_rs1_data;
         rs2_data_d  = i_id_rs2_data;
         imm_d       = i_id_imm;
         alu_ctrl_d  = i_id_alu_ctrl;
         src0_pc_d   = i_id_src0_pc;
         src1_imm_d  = i_id_src1_imm;
         reg_write_d = i_id_reg_write;
         mem_read_d  = i_id_mem_read;
         mem_write_d = i_id_mem_write;
`ifdef ID_EX_FWD_EN
         rs1_addr_d  = i_id_rs1_addr;
         rs2_addr_d  = i_id_rs2_addr;
`endif
      end
      stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_valid_q  <= 1'b0;
         pc_q        <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         alu_ctrl_q  <= '0;
         src0_pc_q   <= 1'b0;
         src1_imm_q  <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         stall_cnt_q <= '0;
`ifdef ID_EX_FWD_EN
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
`endif
      end else begin
         ex_valid_q  <= ex_valid_d;
         pc_q        <= pc_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         alu_ctrl_q  <= alu_ctrl_d;
         src0_pc_q   <= src0_pc_d;
         src1_imm_q  <= src1_imm_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         stall_cnt_q <= stall_cnt_d;
`ifdef ID_EX_FWD_EN
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
`endif
      end
   end

   assign o_stall      = stall;
   assign o_ex_valid   = ex_valid_q;
   assign o_alu_ctrl   = alu_ctrl_q;
   assign o_op_0       = src0_pc_q  ? pc_q  : rs1_fwd;
   assign o_op_1       = src1_imm_q ? imm_q : rs2_fwd;
   assign o_store_data = rs2_fwd;
   assign o_pc         = pc_q;
   assign o_rd_addr    = rd_q;
   assign o_reg_write  = ex_valid_q && reg_write_q;
   assign o_mem_read   = ex_valid_q && mem_read_q;
   assign o_mem_write  = ex_valid_q && mem_write_q;
   assign o_stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a reference model
// Honours ID_EX_FWD_EN the same way as the design.
module tb_id_ex_stage;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         id_valid;
   logic [W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]   id_rs1, id_rs2, id_rd;
   logic [3:0]   id_alu;
   logic         id_src0_pc, id_src1_imm, id_rw, id_mr, id_mw;
   logic         flush;
   logic [4:0]   exm_rd, mwb_rd;
   logic         exm_rw, mwb_rw;
   logic [W-1:0] exm_res, mwb_res;
   logic         stall, ex_valid, reg_write, mem_read, mem_write;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] op_0, op_1, store_data, pc;
   logic [4:0]   rd_addr;
   logic [31:0]  stall_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_pc(id_pc),
      .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2), .i_id_rd_addr(id_rd),
      .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
      .i_id_alu_ctrl(id_alu), .i_id_src0_pc(id_src0_pc), .i_id_src1_imm(id_src1_imm),
      .i_id_reg_write(id_rw), .i_id_mem_read(id_mr), .i_id_mem_write(id_mw),
      .i_flush(flush),
      .i_exm_rd_addr(exm_rd), .i_exm_reg_write(exm_rw), .i_exm_result(exm_res),
      .i_mwb_rd_addr(mwb_rd), .i_mwb_reg_write(mwb_rw), .i_mwb_result(mwb_res),
      .o_stall(stall), .o_ex_valid(ex_valid), .o_alu_ctrl(alu_ctrl),
      .o_op_0(op_0), .o_op_1(op_1), .o_store_data(store_data), .o_pc(pc),
      .o_rd_addr(rd_addr), .o_reg_write(reg_write), .o_mem_read(mem_read),
      .o_mem_write(mem_write), .o_stall_cnt(stall_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference view of the instruction sitting in EX
   logic         m_valid, m_src0, m_src1, m_rw, m_mr, m_mw;
   logic [W-1:0] m_pc, m_d1, m_d2, m_imm;
   logic [4:0]   m_a1, m_a2, m_rd;
   logic [3:0]   m_alu;
   logic [31:0]  m_cnt;

   function automatic logic [W-1:0] src_value(input logic [4:0] a, input logic [W-1:0] d);
`ifdef ID_EX_FWD_EN
      if (exm_rw && exm_rd != 0 && exm_rd == a) return exm_res;
      if (mwb_rw && mwb_rd != 0 && mwb_rd == a) return mwb_res;
`endif
      return d;
   endfunction

   function automatic logic pending_write(input logic [4:0] s);
`ifdef ID_EX_FWD_EN
      return s != 0 && m_valid && m_mr && m_rd == s;
`else
      return s != 0 && ((m_valid && m_rw && m_rd == s) || (exm_rw && exm_rd == s) || (mwb_rw && mwb_rd == s));
`endif
   endfunction

   function automatic logic model_stall();
      if (!id_valid || flush) return 1'b0;
      return (!id_src0_pc && pending_write(id_rs1)) || pending_write(id_rs2);
   endfunction

   task automatic model_reset();
      m_valid = 0; m_src0 = 0; m_src1 = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_a1 = 0; m_a2 = 0; m_rd = 0; m_alu = 0;
      m_cnt = 0;
   endtask

   task automatic check_outputs();
      logic [W-1:0] s1, s2;
      s1 = src_value(m_a1, m_d1);
      s2 = src_value(m_a2, m_d2);
      check("stall", {31'd0, stall}, {31'd0, model_stall()});
      check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      check("reg_write", {31'd0, reg_write}, {31'd0, m_valid & m_rw});
      check("mem_read", {31'd0, mem_read}, {31'd0, m_valid & m_mr});
      check("mem_write", {31'd0, mem_write}, {31'd0, m_valid & m_mw});
      check("stall_cnt", stall_cnt, m_cnt);
      if (m_valid) begin
         check("op_0", op_0, m_src0 ? m_pc : s1);
         check("op_1", op_1, m_src1 ? m_imm : s2);
         check("store_data", store_data, s2);
         check("pc", pc, m_pc);
         check("rd_addr", {27'd0, rd_addr}, {27'd0, m_rd});
         check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_alu});
      end
   endtask

   // Called just after a falling edge with inputs settled; advances one full cycle.
   task automatic tick();
      logic es;
      #1;
      check_outputs();
      es = model_stall();
      @(posedge clk);
      if (rst) model_reset();
      else begin
         if (es && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (id_valid && !es && !flush) begin
            m_valid = 1; m_pc = id_pc; m_a1 = id_rs1; m_a2 = id_rs2; m_rd = id_rd;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_alu = id_alu;
            m_src0 = id_src0_pc; m_src1 = id_src1_imm; m_rw = id_rw; m_mr = id_mr; m_mw = id_mw;
         end else begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu = 0; id_src0_pc = 0;
      id_src1_imm = 0; id_rw = 0; id_mr = 0; id_mw = 0;
      exm_rd = 0; exm_rw = 0; exm_res = 0; mwb_rd = 0; mwb_rw = 0; mwb_res = 0;
   endtask

   task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [W-1:0] d1, input logic [W-1:0] imm,
                         input logic src1_imm, input logic rw, input logic mr);
      id_valid = 1; id_pc = 32'h100 + {27'd0, rd, 2'b00}; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = 32'h5A5A_0000 | {27'd0, rs2}; id_imm = imm; id_alu = 4'h3;
      id_src0_pc = 0; id_src1_imm = src1_imm; id_rw = rw; id_mr = mr; id_mw = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      model_reset();
      idle();
      @(negedge clk);
      rst = 1;
      tick();
      rst = 0;
      #1;
      check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_pc", pc, 32'd0);

      // addi x5 then add x6,x5,x5 with EX/MEM returning 0x10
      do_reset();
      set_id(5'd0, 5'd0, 5'd5, 32'd0, 32'h10, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(5'd5, 5'd5, 5'd6, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      #1;
`ifdef ID_EX_FWD_EN
      check("fwd_back2back_nostall", {31'd0, stall}, 32'd0);
      tick();
      idle();
      exm_rd = 5'd5; exm_rw = 1; exm_res = 32'h10;
      #1;
      check("fwd_back2back_op0", op_0, 32'h10);
      check("fwd_back2back_op1", op_1, 32'h10);
      check("fwd_back2back_nostall2", {31'd0, stall}, 32'd0);
      tick();
`else
      check("raw_back2back_stall", {31'd0, stall}, 32'd1);
      tick();
`endif

      // EX/MEM beats MEM/WB for x7
      do_reset();
      set_id(5'd7, 5'd0, 5'd9, 32'h11, 32'd0, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      exm_rd = 5'd7; exm_rw = 1; exm_res = 32'hAA;
      mwb_rd = 5'd7; mwb_rw = 1; mwb_res = 32'hBB;
      #1;
`ifdef ID_EX_FWD_EN
      check("fwd_priority_op0", op_0, 32'hAA);
`else
      check("nofwd_op0", op_0, 32'h11);
`endif
      tick();

      // lw x3 then add x4,x3,x1: one stall, one bubble
      do_reset();
      set_id(5'd1, 5'd0, 5'd3, 32'h40, 32'd4, 1'b1, 1'b1, 1'b1);
      tick();
      set_id(5'd3, 5'd1, 5'd4, 32'h77, 32'd0, 1'b0, 1'b1, 1'b0);
      #1;
      check("lu_stall", {31'd0, stall}, 32'd1);
      tick();
      check("lu_bubble", {31'd0, ex_valid}, 32'd0);
      check("lu_stall_clear", {31'd0, stall}, 32'd0);
      check("lu_stall_cnt", stall_cnt, 32'd1);
      tick();
      idle();
      #1;
      check("lu_add_enters", {31'd0, ex_valid}, 32'd1);
      check("lu_add_rd", {27'd0, rd_addr}, 32'd4);
      tick();

      // Load-use coincident with flush
      do_reset();
      set_id(5'd1, 5'd0, 5'd3, 32'h40, 32'd4, 1'b1, 1'b1, 1'b1);
      tick();
      set_id(5'd3, 5'd1, 5'd4, 32'h77, 32'd0, 1'b0, 1'b1, 1'b0);
      flush = 1;
      #1;
      check("flush_no_stall", {31'd0, stall}, 32'd0);
      tick();
      idle();
      #1;
      check("flush_bubble", {31'd0, ex_valid}, 32'd0);
      tick();

      // x0 is never forwarded
      do_reset();
      set_id(5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      exm_rd = 5'd0; exm_rw = 1; exm_res = 32'hFFFF;
      mwb_rd = 5'd0; mwb_rw = 1; mwb_res = 32'hFFFF;
      tick();
      id_valid = 0;
      #1;
      check("x0_op0", op_0, 32'd0);
      tick();

      // Reset during a load-use stall
      do_reset();
      set_id(5'd1, 5'd0, 5'd3, 32'h40, 32'd4, 1'b1, 1'b1, 1'b1);
      tick();
      set_id(5'd3, 5'd1, 5'd4, 32'h77, 32'd0, 1'b0, 1'b1, 1'b0);
      rst = 1;
      tick();
      rst = 0;
      #1;
      check("rst_mid_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      check("rst_mid_cnt", stall_cnt, 32'd0);
      tick();

      // Random traffic on a small register set to provoke hazards
      for (int i = 0; i < 4000; i++) begin
         rst         = ($urandom_range(0, 59) == 0);
         flush       = ($urandom_range(0, 9) == 0);
         id_valid    = ($urandom_range(0, 4) != 0);
         id_pc       = $urandom;
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_rd       = 5'($urandom_range(0, 3));
         id_rs1_data = $urandom;
         id_rs2_data = $urandom;
         id_imm      = $urandom;
         id_alu      = 4'($urandom);
         id_src0_pc  = ($urandom_range(0, 3) == 0);
         id_src1_imm = ($urandom_range(0, 2) == 0);
         id_rw       = 1'($urandom);
         id_mr       = ($urandom_range(0, 2) == 0);
         id_mw       = ($urandom_range(0, 4) == 0);
         exm_rd      = 5'($urandom_range(0, 3));
         exm_rw      = ($urandom_range(0, 2) == 0);
         exm_res     = $urandom;
         mwb_rd      = 5'($urandom_range(0, 3));
         mwb_rw      = ($urandom_range(0, 2) == 0);
         mwb_res     = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width of operands and results.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_id_valid  in  1  decode stage holds a valid instruction.
- i_id_pc  in  WIDTH  instruction PC.
- i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  in  5 each  register indices.
- i_id_rs1_data, i_id_rs2_data  in  WIDTH each  register-file read data.
- i_id_imm  in  WIDTH  sign-extended immediate.
- i_id_alu_ctrl  in  4  ALU operation code.
- i_id_src0_pc  in  1  operand 0 = PC, not rs1.
- i_id_src1_imm  in  1  operand 1 = imm, not rs2.
- i_id_reg_write, i_id_mem_read, i_id_mem_write  in  1 each  control flags.
- i_flush  in  1  branch redirect; kill ID and EX contents.
- i_exm_rd_addr  in  5;  i_exm_reg_write  in  1;  i_exm_result  in  WIDTH  EX/MEM forward source.
- i_mwb_rd_addr  in  5;  i_mwb_reg_write  in  1;  i_mwb_result  in  WIDTH  MEM/WB forward source.
- o_stall  out  1  hold IF and ID this cycle.
- o_ex_valid  out  1  EX slot holds a live instruction.
- o_alu_ctrl  out  4;  o_op_0, o_op_1  out  WIDTH  ALU inputs.
- o_store_data  out  WIDTH  forwarded rs2 for stores.
- o_pc  out  WIDTH;  o_rd_addr  out  5;  o_reg_write, o_mem_read, o_mem_write  out  1 each.
- o_stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-003 SHALL capture all i_id_* fields into the ID/EX register on a rising edge when i_id_valid=1, o_stall=0, i_flush=0; latency ID->EX is exactly one cycle.
REQ-004 SHALL load a bubble when i_id_valid=0, o_stall=1, or i_flush=1: o_ex_valid=0 and o_reg_write, o_mem_read, o_mem_write=0; data fields are don't-care.
REQ-005 SHALL force o_reg_write, o_mem_read, o_mem_write to 0 whenever o_ex_valid=0.
REQ-006 SHALL forward each EX source (rs1, rs2) combinationally from registered state: EX/MEM match first, else MEM/WB match, else registered register-file data.
REQ-007 SHALL treat a match as source index equal to rd, with rd != 0 and the stage's reg_write=1; x0 SHALL never be forwarded.
REQ-008 SHALL drive o_op_0 = registered PC if src0_pc, else forwarded rs1; o_op_1 = registered imm if src1_imm, else forwarded rs2; o_store_data = forwarded rs2 always.
REQ-009 SHALL assert o_stall (load-use) when i_id_valid=1, o_ex_valid=1, o_mem_read=1, o_rd_addr != 0, and o_rd_addr equals a used ID source: rs1 unless i_id_src0_pc; rs2 always (covers store data).
REQ-010 SHALL deassert o_stall whenever i_flush=1; flush has priority over stall.
REQ-011 SHALL clear a load-use stall after exactly one cycle, since the bubble removes the matching load from EX.
REQ-012 SHALL increment o_stall_cnt on each cycle o_stall=1, saturating at 0xFFFFFFFF.

Reset
REQ-013 SHALL, on i_rst=1 at a rising edge, clear o_ex_valid, all control flags, all registered data fields, and o_stall_cnt to 0.
REQ-014 SHALL give i_rst priority over i_flush, stall, and capture; an in-flight instruction is discarded.
REQ-015 SHALL keep o_stall=0 while o_ex_valid=0 after reset.

Configuration
REQ-016 SHALL support macro ID_EX_FWD_EN: when defined, forwarding per REQ-006..REQ-009 applies.
REQ-017 SHALL, when ID_EX_FWD_EN is undefined, use registered register-file data directly, with no forward muxes.
REQ-018 SHALL, when ID_EX_FWD_EN is undefined, raise o_stall while any used ID source (rd != 0) matches a valid writing rd in EX, EX/MEM, or MEM/WB; REQ-010 still applies.

Verification
REQ-019 SHALL cover: addi x5 then add x6,x5,x5 back-to-back, i_exm_result=0x10 -> o_op_0=o_op_1=0x10, o_stall never asserted.
REQ-020 SHALL cover: EX/MEM rd=7 result 0xAA and MEM/WB rd=7 result 0xBB, EX reads x7 -> o_op_0=0xAA.
REQ-021 SHALL cover: lw x3 then add x4,x3,x1 -> o_stall=1 for one cycle, one bubble (o_ex_valid=0), o_stall_cnt=1, add then enters EX.
REQ-022 SHALL cover: load-use stall coincident with i_flush=1 -> o_stall=0, next o_ex_valid=0.
REQ-023 SHALL cover: write to x0 with result 0xFFFF, next instruction reads x0 with rs1_data=0 -> o_op_0=0.
REQ-024 SHALL cover: i_rst=1 mid-stall -> next cycle o_ex_valid=0, o_stall=0, o_stall_cnt=0.
